fdiv_share_ctrl: RTL and testbench

- Shares one pipelined fdiv unit (fixed latency, one new operation per cycle, no stall input) between two requesters, e.g. FPU issue lane 0 and lane 1.
- Round-robin arbitration; operands are registered into the divider.
- Each in-flight operation's owner and tag travel in a shadow pipeline.
- Results land in per-requester response buffers with valid/ready backpressure; credit gating guarantees no result is ever dropped.

---
 rtl/fdiv_share_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fdiv_share_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_share_ctrl.sv
// Round-robin sharing of one fixed-latency pipelined fdiv between two lanes.
// Owner/tag ride a shadow pipeline; per-lane credits keep results from dropping.
module fdiv_share_ctrl #(
  parameter int DIV_LAT   = 4,
  parameter int TAG_W     = 6,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_y,
  output logic             rsp0_ovf,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_y,
  output logic             rsp1_ovf,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [31:0]      div_x1,
  output logic [31:0]      div_x2,
  input  logic [31:0]      div_y,
  input  logic             div_ovf,
  output logic             busy
);

  localparam int NS = DIV_LAT + 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int EW = 33 + TAG_W;

  logic [1:0]             req_v, rsp_rdy, rsp_v;
  logic [1:0]             elig, gnt, pop, wr;
  logic [1:0][31:0]       req_x1, req_x2;
  logic [1:0][TAG_W-1:0]  req_tag;

  logic                   ptr_q, ptr_d;
  logic [1:0][CW-1:0]     cred_q, cred_d;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0][AW-1:0]     wp_q, wp_d;
  logic [1:0][AW-1:0]     rp_q, rp_d;
  logic [1:0][BUF_DEPTH-1:0][EW-1:0] mem_q, mem_d;

  logic [NS-1:0]             shv_q, shv_d;
  logic [NS-1:0]             shl_q, shl_d;
  logic [NS-1:0][TAG_W-1:0]  sht_q, sht_d;
  logic [31:0]               x1_q, x1_d, x2_q, x2_d;

  logic          blk;
  logic          cap_l;
  logic [EW-1:0] cap_e;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign req_v   = {req1_valid, req0_valid};
  assign req_x1  = {req1_x1, req0_x1};
  assign req_x2  = {req1_x2, req0_x2};
  assign req_tag = {req1_tag, req0_tag};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign blk     = rst | flush;

  // Credit = in flight + buffered, so a grant always has a buffer slot waiting.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_v[i] && (cred_q[i] < CW'(BUF_DEPTH));
    end
  end

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!blk) begin
      unique case (elig)
        2'b11: begin
          gnt[ptr_q] = 1'b1;
          ptr_d      = ~ptr_q;
        end
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (flush) ptr_d = 1'b0;
  end

  assign pop   = rsp_v & rsp_rdy & {2{~flush}};
  assign cap_l = shl_q[NS-1];
  assign cap_e = {div_y, div_ovf, sht_q[NS-1]};
  assign wr[0] = shv_q[NS-1] & ~cap_l & ~flush;
  assign wr[1] = shv_q[NS-1] &  cap_l & ~flush;

  always_comb begin
    shv_d = {shv_q[NS-2:0], |gnt};
    shl_d = {shl_q[NS-2:0], gnt[1]};
    sht_d = {sht_q[NS-2:0], gnt[1] ? req_tag[1] : req_tag[0]};
    x1_d  = x1_q;
    x2_d  = x2_q;
    if (|gnt) begin
      x1_d = gnt[1] ? req_x1[1] : req_x1[0];
      x2_d = gnt[1] ? req_x2[1] : req_x2[0];
    end
    if (flush) shv_d = '0;
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      cred_d[i] = cred_q[i] + CW'(gnt[i]) - CW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CW'(wr[i]) - CW'(pop[i]);
      wp_d[i]   = wr[i] ? inc(wp_q[i]) : wp_q[i];
      rp_d[i]   = pop[i] ? inc(rp_q[i]) : rp_q[i];
      if (wr[i]) mem_d[i][wp_q[i]] = cap_e;
      if (flush) begin
        cred_d[i] = '0;
        cnt_d[i]  = '0;
        wp_d[i]   = '0;
        rp_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= 1'b0;
      cred_q <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      shv_q  <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      shv_q  <= shv_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
    end
  end

  always_ff @(posedge clk) begin
    shl_q <= shl_d;
    sht_q <= sht_d;
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_v[i] = (cnt_q[i] != '0);
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_y     = mem_q[0][rp_q[0]][EW-1 -: 32];
  assign rsp0_ovf   = mem_q[0][rp_q[0]][TAG_W];
  assign rsp0_tag   = mem_q[0][rp_q[0]][TAG_W-1:0];
  assign rsp1_y     = mem_q[1][rp_q[1]][EW-1 -: 32];
  assign rsp1_ovf   = mem_q[1][rp_q[1]][TAG_W];
  assign rsp1_tag   = mem_q[1][rp_q[1]][TAG_W-1:0];
  assign div_x1     = x1_q;
  assign div_x2     = x2_q;
  assign busy       = (|shv_q) | (|rsp_v);

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// Bench for fdiv_share_ctrl: fake fdiv pipeline plus a queue-based
// reference model of issue, capture, buffering, flush and reset.
module tb_fdiv_share_ctrl;

  localparam int DIV_LAT = 4;
  localparam int TAG_W   = 6;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst, flush;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic rsp0_valid, rsp0_ready, rsp0_ovf;
  logic rsp1_valid, rsp1_ready, rsp1_ovf;
  logic [31:0] rsp0_y, rsp1_y;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic [31:0] div_x1, div_x2, div_y;
  logic div_ovf, busy;

  always #5 clk = ~clk;

  fdiv_share_ctrl #(
    .DIV_LAT(DIV_LAT), .TAG_W(TAG_W), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_y(rsp0_y), .rsp0_ovf(rsp0_ovf), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_y(rsp1_y), .rsp1_ovf(rsp1_ovf), .rsp1_tag(rsp1_tag),
    .div_x1(div_x1), .div_x2(div_x2),
    .div_y(div_y), .div_ovf(div_ovf), .busy(busy)
  );

  // Stand-in divider: exact for divisor 2.0, otherwise an arbitrary mix.
  function automatic logic [32:0] fdiv_fn(input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'h0) return {1'b1, 32'h7F80_0000};
    if (b == 32'h4000_0000) return {1'b0, a - 32'h0080_0000};
    return {1'b0, a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_5A5A};
  endfunction

  logic [32:0] dpipe [DIV_LAT];
  initial for (int k = 0; k < DIV_LAT; k++) dpipe[k] = '0;
  always @(posedge clk) begin
    dpipe[0] <= fdiv_fn(div_x1, div_x2);
    for (int k = 1; k < DIV_LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign {div_ovf, div_y} = dpipe[DIV_LAT-1];

  typedef struct {
    logic             lane;
    logic [TAG_W-1:0] tag;
    logic [31:0]      x1;
    logic [31:0]      x2;
    int               cap;
  } op_t;
  typedef struct {
    logic [31:0]      y;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } res_t;

  op_t  infl[$];
  res_t mb0[$];
  res_t mb1[$];
  int   edge_n = 0;
  logic mptr = 1'b0;
  logic [31:0] mdx1 = '0, mdx2 = '0;
  logic [1:0]  last_gnt;
  int   nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, take the edge, update model.
  task automatic cycle();
    int   oc[2];
    logic [1:0] el, eg;
    op_t  o;
    res_t r;
    logic [32:0] d;
    #1;
    oc[0] = mb0.size();
    oc[1] = mb1.size();
    foreach (infl[k]) oc[infl[k].lane]++;
    el[0] = req0_valid && (oc[0] < DEPTH);
    el[1] = req1_valid && (oc[1] < DEPTH);
    eg = 2'b00;
    if (!rst && !flush) begin
      if (el == 2'b11) eg[mptr] = 1'b1;
      else eg = el;
    end
    last_gnt = eg;
    chk("req0_ready", req0_ready, eg[0]);
    chk("req1_ready", req1_ready, eg[1]);
    chk("rsp0_valid", rsp0_valid, mb0.size() != 0);
    chk("rsp1_valid", rsp1_valid, mb1.size() != 0);
    if (mb0.size() != 0) begin
      chk("rsp0_y", rsp0_y, mb0[0].y);
      chk("rsp0_ovf", rsp0_ovf, mb0[0].ovf);
      chk("rsp0_tag", rsp0_tag, mb0[0].tag);
    end
    if (mb1.size() != 0) begin
      chk("rsp1_y", rsp1_y, mb1[0].y);
      chk("rsp1_ovf", rsp1_ovf, mb1[0].ovf);
      chk("rsp1_tag", rsp1_tag, mb1[0].tag);
    end
    chk("busy", busy, (infl.size() + mb0.size() + mb1.size()) != 0);
    chk("div_x1", div_x1, mdx1);
    chk("div_x2", div_x2, mdx2);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      infl.delete(); mb0.delete(); mb1.delete();
      mptr = 1'b0; mdx1 = '0; mdx2 = '0;
    end else if (flush) begin
      infl.delete(); mb0.delete(); mb1.delete();
      mptr = 1'b0;
    end else begin
      if (rsp0_ready && mb0.size() != 0) void'(mb0.pop_front());
      if (rsp1_ready && mb1.size() != 0) void'(mb1.pop_front());
      while (infl.size() != 0 && infl[0].cap == edge_n) begin
        o = infl.pop_front();
        d = fdiv_fn(o.x1, o.x2);
        r.y = d[31:0]; r.ovf = d[32]; r.tag = o.tag;
        if (o.lane) mb1.push_back(r);
        else mb0.push_back(r);
      end
      if (eg != 2'b00) begin
        o.lane = eg[1];
        o.tag  = eg[1] ? req1_tag : req0_tag;
        o.x1   = eg[1] ? req1_x1 : req0_x1;
        o.x2   = eg[1] ? req1_x2 : req0_x2;
        o.cap  = edge_n + DIV_LAT + 1;
        infl.push_back(o);
        mdx1 = o.x1;
        mdx2 = o.x2;
        if (el == 2'b11) mptr = ~mptr;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_div();
    return ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
  endfunction

  task automatic rnd_req(input int p0, input int p1);
    req0_valid = $urandom_range(0, 99) < p0;
    req1_valid = $urandom_range(0, 99) < p1;
    req0_x1 = $urandom; req0_x2 = rnd_div(); req0_tag = TAG_W'($urandom);
    req1_x1 = $urandom; req1_x2 = rnd_div(); req1_tag = TAG_W'($urandom);
  endtask

  initial begin
    int g;
    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x1 = '0; req0_x2 = '0; req0_tag = '0;
    req1_x1 = '0; req1_x2 = '0; req1_tag = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(); cycle();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_divx1", div_x1, 32'h0);
    cycle(); cycle();

    // single op 3.0 / 2.0
    req0_valid = 1'b1; req0_x1 = 32'h4040_0000;
    req0_x2 = 32'h4000_0000; req0_tag = 6'd5;
    cycle();
    req0_valid = 1'b0;
    chk("single_x1", div_x1, 32'h4040_0000);
    for (int k = 0; k < 4; k++) cycle();
    chk("single_early", rsp0_valid, 1'b0);
    cycle();
    chk("single_valid", rsp0_valid, 1'b1);
    chk("single_y", rsp0_y, 32'h3FC0_0000);
    chk("single_tag", rsp0_tag, 32'd5);
    chk("single_rsp1", rsp1_valid, 1'b0);
    rsp0_ready = 1'b1;
    cycle(); cycle();

    // contention: both lanes every cycle, consumers always ready
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req0_x1 = $urandom; req0_x2 = rnd_div(); req0_tag = TAG_W'(k);
      req1_x1 = $urandom; req1_x2 = rnd_div(); req1_tag = TAG_W'(k + 32);
      cycle();
      chk("alt_gnt", last_gnt, (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 8; k++) cycle();

    // backpressure on lane 0
    rsp0_ready = 1'b0; req0_valid = 1'b1; g = 0;
    for (int k = 0; k < 12; k++) begin
      req0_x1 = $urandom; req0_x2 = 32'h4000_0000; req0_tag = TAG_W'(k);
      cycle();
      g += int'(last_gnt[0]);
    end
    chk("bp_grants", g, 32'd4);
    rsp0_ready = 1'b1;
    cycle();
    g = int'(last_gnt[0]);
    rsp0_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      g += int'(last_gnt[0]);
    end
    chk("bp_one_more", g, 32'd1);
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();

    // random traffic, random backpressure (push/pop overlap included)
    for (int k = 0; k < 400; k++) begin
      rnd_req(70, 70);
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
      cycle();
    end

    // flush with work in flight and buffered
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rnd_req(100, 50);
      cycle();
    end
    flush = 1'b1; rsp0_ready = 1'b1;
    cycle();
    flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_rsp0", rsp0_valid, 1'b0);
    for (int k = 0; k < 10; k++) cycle();
    req0_valid = 1'b1; req0_x2 = 32'h4000_0000;
    cycle();
    chk("post_flush_gnt", last_gnt, 32'd1);
    req0_valid = 1'b0; rsp1_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();

    // reset mid-stream
    for (int k = 0; k < 8; k++) begin
      rnd_req(80, 80);
      rsp0_ready = $urandom_range(0, 1);
      cycle();
    end
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(); cycle();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_divx2", div_x2, 32'h0);
    for (int k = 0; k < 10; k++) cycle();
    for (int k = 0; k < 60; k++) begin
      rnd_req(60, 60);
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    chk("drain_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
